// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: ALU operations, instruction formats, opcodes.
// Also holds the funct3/funct7 ALU decode shared by R-type and I-ALU instructions.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASSB,
    ALU_AUIPC
  } alu_op_e;

  typedef enum logic [2:0] {
    IT_R,
    IT_I,
    IT_S,
    IT_B,
    IT_U,
    IT_J
  } instr_type_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // sub_ok is set only for R-type: immediates have no SUB, so ADDI ignores funct7.
  function automatic alu_op_e alu_from_funct(input logic [2:0] funct3,
                                             input logic       funct7_b5,
                                             input logic       sub_ok);
    alu_op_e op;
    case (funct3)
      3'b000:  op = (sub_ok && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cu.sv
// Combinational control unit: opcode/funct3/funct7[5] to execute-stage flags, ALU op and format.
// Unknown opcodes decode to a harmless R-type ADD with every flag cleared.
module cu
  import riscv_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_b5,
  output alu_op_e     alu_op,
  output instr_type_e instr_type,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        use_imm,
  output logic        is_branch,
  output logic        is_jump,
  output logic        is_jalr
);

  always_comb begin
    alu_op     = ALU_ADD;
    instr_type = IT_R;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    use_imm    = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    is_jalr    = 1'b0;
    case (opcode)
      OP_R: begin
        reg_write = 1'b1;
        alu_op    = alu_from_funct(funct3, funct7_b5, 1'b1);
      end
      OP_IALU: begin
        instr_type = IT_I;
        reg_write  = 1'b1;
        use_imm    = 1'b1;
        alu_op     = alu_from_funct(funct3, funct7_b5, 1'b0);
      end
      OP_LOAD: begin
        instr_type = IT_I;
        mem_read   = 1'b1;
        reg_write  = 1'b1;
        use_imm    = 1'b1;
      end
      OP_STORE: begin
        instr_type = IT_S;
        mem_write  = 1'b1;
        use_imm    = 1'b1;
      end
      OP_BRANCH: begin
        instr_type = IT_B;
        is_branch  = 1'b1;
        alu_op     = ALU_SUB;
      end
      OP_JAL: begin
        instr_type = IT_J;
        is_jump    = 1'b1;
        reg_write  = 1'b1;
        use_imm    = 1'b1;
      end
      OP_JALR: begin
        instr_type = IT_I;
        is_jump    = 1'b1;
        is_jalr    = 1'b1;
        reg_write  = 1'b1;
        use_imm    = 1'b1;
      end
      OP_LUI: begin
        instr_type = IT_U;
        reg_write  = 1'b1;
        use_imm    = 1'b1;
        alu_op     = ALU_PASSB;
      end
      OP_AUIPC: begin
        instr_type = IT_U;
        reg_write  = 1'b1;
        use_imm    = 1'b1;
        alu_op     = ALU_AUIPC;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm.sv
// Immediate generator: sign-extended immediate for the decoded instruction format.
// Purely combinational; R-type and unknown formats give zero.
module imm
  import riscv_pkg::*;
(
  input  logic [31:7]  ins,
  input  instr_type_e  instr_type,
  output logic [31:0]  sext_imm
);

  always_comb begin
    sext_imm = '0;
    case (instr_type)
      IT_I: sext_imm = {{20{ins[31]}}, ins[31:20]};
      IT_S: sext_imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IT_B: sext_imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IT_U: sext_imm = {ins[31:12], 12'b0};
      IT_J: sext_imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: sext_imm = '0;
    endcase
  end

endmodule

// File: rtl/reg_file.sv
// 32x32 register file, two combinational read ports with write-through bypass, one write port.
// RF_DUMP_EN: when defined, dump=1 prints all registers (pre-edge values) on each rising clk.
module reg_file
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  a3,
  input  logic [31:0] wd,
  input  logic        we3,
  input  logic        dump,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [0:31];
  logic        wr_ok;

  assign wr_ok = we3 && !reset && (a3 != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[a3] <= wd;
    end
  end

  // regs[0] is never written, but x0 is still forced to zero on the read side.
  always_comb begin
    rd1 = regs[ra1];
    if (ra1 == 5'd0) begin
      rd1 = '0;
    end else if (wr_ok && (a3 == ra1)) begin
      rd1 = wd;
    end
  end

  always_comb begin
    rd2 = regs[ra2];
    if (ra2 == 5'd0) begin
      rd2 = '0;
    end else if (wr_ok && (a3 == ra2)) begin
      rd2 = wd;
    end
  end

`ifdef RF_DUMP_EN
  always @(posedge clk) begin
    if (dump) begin
      for (int i = 0; i < 32; i++) begin
        $display("x%0d = %08h", i, regs[i]);
      end
    end
  end
`else
  logic unused_dump;
  assign unused_dump = dump;
`endif

endmodule

// File: rtl/cu_imm_reg_file.sv
// RV32I decode-stage core: register file, control unit and immediate generator, all zero-latency.
// RF_DUMP_EN: enables the register-file dump on the dump port; otherwise dump is ignored.
module cu_imm_reg_file
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [4:0]  a3,
  input  logic [31:0] wd,
  input  logic        we3,
  input  logic        dump,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val,
  output alu_op_e     alu_op,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        use_imm,
  output logic        is_branch,
  output logic        is_jump,
  output logic        is_jalr,
  output instr_type_e instr_type,
  output logic [31:0] sext_imm
);

  instr_type_e itype;

  assign instr_type = itype;

  reg_file u_reg_file (
    .clk   (clk),
    .reset (reset),
    .ra1   (instruction[19:15]),
    .ra2   (instruction[24:20]),
    .a3    (a3),
    .wd    (wd),
    .we3   (we3),
    .dump  (dump),
    .rd1   (rs1_val),
    .rd2   (rs2_val)
  );

  cu u_cu (
    .opcode     (instruction[6:0]),
    .funct3     (instruction[14:12]),
    .funct7_b5  (instruction[30]),
    .alu_op     (alu_op),
    .instr_type (itype),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .use_imm    (use_imm),
    .is_branch  (is_branch),
    .is_jump    (is_jump),
    .is_jalr    (is_jalr)
  );

  imm u_imm (
    .ins        (instruction[31:7]),
    .instr_type (itype),
    .sext_imm   (sext_imm)
  );

endmodule

// File: tb/tb_cu_imm_reg_file.sv
// Randomized bench for cu_imm_reg_file against an array/arithmetic reference model.
module tb_cu_imm_reg_file;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [4:0]  a3;
  logic [31:0] wd;
  logic        we3;
  logic        dump;
  logic [31:0] rs1_val, rs2_val, sext_imm;
  alu_op_e     alu_op;
  instr_type_e instr_type;
  logic        mem_read, mem_write, reg_write, use_imm, is_branch, is_jump, is_jalr;

  int tests = 0;
  int fails = 0;
  logic [31:0] model [32];

  always #5 clk = ~clk;

  cu_imm_reg_file dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .a3          (a3),
    .wd          (wd),
    .we3         (we3),
    .dump        (dump),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .alu_op      (alu_op),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .use_imm     (use_imm),
    .is_branch   (is_branch),
    .is_jump     (is_jump),
    .is_jalr     (is_jalr),
    .instr_type  (instr_type),
    .sext_imm    (sext_imm)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Expected decode computed from the format rules with plain arithmetic.
  task automatic ref_decode(input logic [31:0] ins, output logic [3:0] alu,
                            output logic [2:0] ty, output logic [6:0] flags,
                            output logic [31:0] immv);
    alu_op_e base [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    int f3 = int'(ins[14:12]);
    int v;
    alu_op_e ar = base[f3];
    if (f3 == 5 && ins[30]) ar = ALU_SRA;
    alu = 4'(ALU_ADD);
    ty = 3'(IT_R);
    flags = 7'b0;
    case (ins[6:0])
      7'b0110011: begin flags = 7'b0010000; alu = (f3 == 0 && ins[30]) ? 4'(ALU_SUB) : 4'(ar); end
      7'b0010011: begin flags = 7'b0011000; ty = 3'(IT_I); alu = 4'(ar); end
      7'b0000011: begin flags = 7'b1011000; ty = 3'(IT_I); end
      7'b0100011: begin flags = 7'b0101000; ty = 3'(IT_S); end
      7'b1100011: begin flags = 7'b0000100; ty = 3'(IT_B); alu = 4'(ALU_SUB); end
      7'b1101111: begin flags = 7'b0011010; ty = 3'(IT_J); end
      7'b1100111: begin flags = 7'b0011011; ty = 3'(IT_I); end
      7'b0110111: begin flags = 7'b0011000; ty = 3'(IT_U); alu = 4'(ALU_PASSB); end
      7'b0010111: begin flags = 7'b0011000; ty = 3'(IT_U); alu = 4'(ALU_AUIPC); end
      default: ;
    endcase
    case (ty)
      3'(IT_I): v = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
      3'(IT_S): v = int'(ins[31:25]) * 32 + int'(ins[11:7]) - (ins[31] ? 4096 : 0);
      3'(IT_B): v = int'(ins[11:8]) * 2 + int'(ins[30:25]) * 32 + (ins[7] ? 2048 : 0)
                    - (ins[31] ? 4096 : 0);
      3'(IT_U): v = int'(ins[31:12]) * 4096;
      3'(IT_J): v = int'(ins[30:21]) * 2 + (ins[20] ? 2048 : 0) + int'(ins[19:12]) * 4096
                    - (ins[31] ? 1048576 : 0);
      default:  v = 0;
    endcase
    immv = 32'(v);
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] ra);
    if (ra == 5'd0) return 32'h0;
    if (we3 && !reset && a3 == ra) return wd;
    return model[ra];
  endfunction

  // One cycle: drive at negedge, compare 1ns later, retire the write into the model at posedge.
  task automatic cycle(input logic [31:0] ins, input logic we, input logic [4:0] a,
                       input logic [31:0] d);
    logic [3:0] ealu; logic [2:0] ety; logic [6:0] efl; logic [31:0] eimm;
    @(negedge clk);
    instruction = ins; we3 = we; a3 = a; wd = d;
    #1;
    ref_decode(ins, ealu, ety, efl, eimm);
    chk("rs1_val", rs1_val, ref_read(ins[19:15]));
    chk("rs2_val", rs2_val, ref_read(ins[24:20]));
    chk("alu_op", 32'(alu_op), 32'(ealu));
    chk("instr_type", 32'(instr_type), 32'(ety));
    chk("flags", 32'({mem_read, mem_write, reg_write, use_imm, is_branch, is_jump, is_jalr}),
        32'(efl));
    chk("sext_imm", sext_imm, eimm);
    @(posedge clk);
    if (we && a != 5'd0 && !reset) model[a] = d;
  endtask

  task automatic directed(input string tag, input logic [31:0] ins,
                          input alu_op_e ealu, input logic [31:0] eimm);
    cycle(ins, 1'b0, 5'd0, 32'h0);
    chk({tag, "_alu"}, 32'(alu_op), 32'(ealu));
    chk({tag, "_imm"}, sext_imm, eimm);
  endtask

  initial begin
    logic [6:0]  ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'h7F};
    logic [31:0] ins;
    logic [4:0]  a;
    reset = 1'b1; instruction = 32'h0; a3 = 5'd0; wd = 32'h0; we3 = 1'b0; dump = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset state, including bypass suppression while reset is high.
    @(negedge clk);
    instruction = {7'b0, 5'd3, 5'd5, 3'b0, 5'd0, 7'b0110011}; we3 = 1'b1; a3 = 5'd5; wd = 32'hFFFF;
    #1;
    chk("reset_rs1", rs1_val, 32'h0);
    chk("reset_rs2", rs2_val, 32'h0);
    @(negedge clk);
    we3 = 1'b0; reset = 1'b0;

    for (int r = 1; r < 32; r += 2)
      cycle({7'b0, 5'(r + 1), 5'(r), 3'b0, 5'd0, 7'b0110011}, 1'b0, 5'd0, 32'h0);

    // x0 is never written; bypass to rs1=5 visible in the write cycle and after it.
    cycle({12'h0, 5'd0, 3'b0, 5'd0, 7'b0010011}, 1'b1, 5'd0, 32'hDEADBEEF);
    cycle({12'h0, 5'd0, 3'b0, 5'd0, 7'b0010011}, 1'b0, 5'd0, 32'h0);
    chk("x0_after_write", rs1_val, 32'h0);
    cycle({7'b0, 5'd0, 5'd5, 3'b0, 5'd1, 7'b0110011}, 1'b1, 5'd5, 32'h1234);
    chk("bypass_x5", rs1_val, 32'h1234);
    cycle({7'b0, 5'd0, 5'd5, 3'b0, 5'd1, 7'b0110011}, 1'b0, 5'd0, 32'h0);
    chk("stored_x5", rs1_val, 32'h1234);

    directed("sub",  32'h40B50533, ALU_SUB,   32'h0);
    directed("add",  32'h00B50533, ALU_ADD,   32'h0);
    directed("addi", 32'hFFC10093, ALU_ADD,   32'hFFFFFFFC);
    directed("srai", 32'h41F0D093, ALU_SRA,   32'h0000041F);
    directed("beq",  32'hFE208EE3, ALU_SUB,   32'hFFFFFFFC);
    directed("jal",  32'h008000EF, ALU_ADD,   32'h00000008);
    directed("lui",  32'h123450B7, ALU_PASSB, 32'h12345000);
    directed("bad",  32'h0000007F, ALU_ADD,   32'h0);

    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 9)];
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) ins[19:15] = a;
      if ($urandom_range(0, 3) == 0) ins[24:20] = a;
      cycle(ins, 1'($urandom_range(0, 1)), a, $urandom);
    end

    // Reset arriving mid-cycle during a write: registers clear at once and the write is lost.
    @(negedge clk);
    instruction = {7'b0, 5'd9, 5'd7, 3'b0, 5'd0, 7'b0110011}; we3 = 1'b1; a3 = 5'd7; wd = 32'hCAFE0007;
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_rs1", rs1_val, 32'h0);
    chk("midreset_rs2", rs2_val, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; we3 = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int r = 1; r < 32; r += 3)
      cycle({7'b0, 5'(31 - r), 5'(r), 3'b0, 5'd0, 7'b0110011}, 1'b0, 5'd0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
